// File: rtl/alu_pkg.sv
// Shared constants for the ALU: operand width, opcode map and flag-vector bit positions.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SLL  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h2;
    localparam logic [3:0] OP_SLTU = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'hD;

    // Bit positions inside the packed flag vector {ZF,CF,OF,SF}
    localparam int FR_ZF = 3;
    localparam int FR_CF = 2;
    localparam int FR_OF = 1;
    localparam int FR_SF = 0;

    // Ops that drive the shared adder in subtract mode
    function automatic logic needs_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath and the ALU; ALU_FR exists only when ALU_FR_EN is defined.
interface alu_if;
    import alu_pkg::*;

    logic [3:0]       ALU_OP;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH-1:0] ALU_F;
    logic             ZF;
    logic             CF;
    logic             OF;
    logic             SF;
`ifdef ALU_FR_EN
    logic [3:0]       ALU_FR;
`endif

    modport master (
`ifdef ALU_FR_EN
        input  ALU_FR,
`endif
        output ALU_OP, ALU_A, ALU_B,
        input  ALU_F, ZF, CF, OF, SF
    );

    modport slave (
`ifdef ALU_FR_EN
        output ALU_FR,
`endif
        input  ALU_OP, ALU_A, ALU_B,
        output ALU_F, ZF, CF, OF, SF
    );

endinterface

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor (A + (B^sub) + sub) shared by ADD, SUB, SLT and SLTU.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    assign full_sum  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum       = full_sum[WIDTH-1:0];
    assign carry_out = full_sum[WIDTH];

    // Operands (after inversion) agree in sign but the result does not
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// 32-bit registered ALU: op mux, condition flags, one-cycle output registers.
// Optional build macro ALU_FR_EN adds the packed flag output ALU_FR = {ZF,CF,OF,SF}.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             sub_sel;

    logic [WIDTH-1:0] f_next;
    logic             zf_next;
    logic             cf_next;
    logic             of_next;
    logic             sf_next;

    logic [WIDTH-1:0] f_reg;
    logic             zf_reg;
    logic             cf_reg;
    logic             of_reg;
    logic             sf_reg;

    logic [SHAMT_W-1:0] shamt;
    logic               slt_bit;
    logic               sltu_bit;

    assign sub_sel = needs_sub(bus.ALU_OP);
    assign shamt   = bus.ALU_B[SHAMT_W-1:0];

    alu_addsub u_addsub (
        .a         (bus.ALU_A),
        .b         (bus.ALU_B),
        .sub       (sub_sel),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Signed less-than is the true sign of A-B, corrected for overflow; unsigned is the borrow
    assign slt_bit  = sum[WIDTH-1] ^ overflow;
    assign sltu_bit = ~carry_out;

    always_comb begin
        f_next  = '0;
        cf_next = 1'b0;
        of_next = 1'b0;
        case (bus.ALU_OP)
            OP_ADD: begin
                f_next  = sum;
                cf_next = carry_out;
                of_next = overflow;
            end
            OP_SUB: begin
                f_next  = sum;
                cf_next = ~carry_out;
                of_next = overflow;
            end
            OP_SLT:  f_next = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: f_next = {{(WIDTH-1){1'b0}}, sltu_bit};
            OP_SLL:  f_next = bus.ALU_A << shamt;
            OP_SRL:  f_next = bus.ALU_A >> shamt;
            OP_SRA:  f_next = $unsigned($signed(bus.ALU_A) >>> shamt);
            OP_XOR:  f_next = bus.ALU_A ^ bus.ALU_B;
            OP_OR:   f_next = bus.ALU_A | bus.ALU_B;
            OP_AND:  f_next = bus.ALU_A & bus.ALU_B;
            default: f_next = '0;
        endcase
        zf_next = (f_next == '0);
        sf_next = f_next[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_reg  <= '0;
            zf_reg <= 1'b0;
            cf_reg <= 1'b0;
            of_reg <= 1'b0;
            sf_reg <= 1'b0;
        end else begin
            f_reg  <= f_next;
            zf_reg <= zf_next;
            cf_reg <= cf_next;
            of_reg <= of_next;
            sf_reg <= sf_next;
        end
    end

    assign bus.ALU_F = f_reg;
    assign bus.ZF    = zf_reg;
    assign bus.CF    = cf_reg;
    assign bus.OF    = of_reg;
    assign bus.SF    = sf_reg;

`ifdef ALU_FR_EN
    logic [3:0] fr_next;
    logic [3:0] fr_reg;

    always_comb begin
        fr_next        = '0;
        fr_next[FR_ZF] = zf_next;
        fr_next[FR_CF] = cf_next;
        fr_next[FR_OF] = of_next;
        fr_next[FR_SF] = sf_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fr_reg <= '0;
        end else begin
            fr_reg <= fr_next;
        end
    end

    assign bus.ALU_FR = fr_reg;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes hand-computed expectations, a monitor pops one per result cycle.
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] f;
        logic        zf;
        logic        cf;
        logic        of;
        logic        sf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_valid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] f,
                         input logic zf, input logic cf, input logic of, input logic sf);
        exp_t e;
        @(negedge clk);
        bus.ALU_OP = op;
        bus.ALU_A  = a;
        bus.ALU_B  = b;
        in_valid   = 1'b1;
        e.name = name; e.f = f; e.zf = zf; e.cf = cf; e.of = of; e.sf = sf;
        exp_q.push_back(e);
    endtask

    // Result for inputs sampled at edge N is visible just after edge N
    always @(posedge clk) out_valid <= in_valid & ~rst;

    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got F=0x%08h expected no pending result", bus.ALU_F);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_F"},  bus.ALU_F, mon_e.f);
                check({mon_e.name, "_ZF"}, {31'b0, bus.ZF}, {31'b0, mon_e.zf});
                check({mon_e.name, "_CF"}, {31'b0, bus.CF}, {31'b0, mon_e.cf});
                check({mon_e.name, "_OF"}, {31'b0, bus.OF}, {31'b0, mon_e.of});
                check({mon_e.name, "_SF"}, {31'b0, bus.SF}, {31'b0, mon_e.sf});
`ifdef ALU_FR_EN
                check({mon_e.name, "_FR"}, {28'b0, bus.ALU_FR},
                      {28'b0, mon_e.zf, mon_e.cf, mon_e.of, mon_e.sf});
`endif
                $display("txn %-10s F=0x%08h ZF=%0b CF=%0b OF=%0b SF=%0b", mon_e.name,
                         bus.ALU_F, bus.ZF, bus.CF, bus.OF, bus.SF);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cycles;
        bus.ALU_OP = OP_ADD;
        bus.ALU_A  = 32'h8000_0000;
        bus.ALU_B  = 32'h8000_0000;

        // Reset held for two edges with a live operation on the inputs
        repeat (2) @(posedge clk);
        #1;
        check("rst_F",  bus.ALU_F, 32'h0);
        check("rst_ZF", {31'b0, bus.ZF}, 32'h0);
        check("rst_CF", {31'b0, bus.CF}, 32'h0);
        check("rst_OF", {31'b0, bus.OF}, 32'h0);
        check("rst_SF", {31'b0, bus.SF}, 32'h0);
`ifdef ALU_FR_EN
        check("rst_FR", {28'b0, bus.ALU_FR}, 32'h0);
`endif
        $display("txn reset      F=0x%08h ZF=%0b CF=%0b OF=%0b SF=%0b", bus.ALU_F, bus.ZF, bus.CF, bus.OF, bus.SF);
        @(negedge clk);
        rst = 1'b0;

        //       name          op       A             B             F             ZF    CF    OF    SF
        issue("and",         OP_AND,  32'h00000003, 32'h00000607, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("or",          OP_OR,   32'h00000003, 32'h00000607, 32'h00000607, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("xor",         OP_XOR,  32'h00000003, 32'h00000607, 32'h00000604, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("add",         OP_ADD,  32'h00000003, 32'h00000607, 32'h0000060A, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("sub",         OP_SUB,  32'h00000003, 32'h00000607, 32'hFFFFF9FC, 1'b0, 1'b1, 1'b0, 1'b1);
        issue("slt",         OP_SLT,  32'h00000003, 32'h00000607, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("sltu",        OP_SLTU, 32'h00000003, 32'h00000607, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("add_ovf",     OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0);
        issue("sub_ovf",     OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        issue("slt_ovf",     OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("sltu_big",    OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("slt_rev",     OP_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("sub_eq",      OP_SUB,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("add_wrap",    OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        issue("add_pos_ovf", OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
        issue("sll4",        OP_SLL,  32'h80000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("srl4",        OP_SRL,  32'h80000001, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("sra4",        OP_SRA,  32'h80000001, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b1);
        issue("sra32",       OP_SRA,  32'h80000001, 32'h00000020, 32'h80000001, 1'b0, 1'b0, 1'b0, 1'b1);
        issue("sll_hi_b",    OP_SLL,  32'h00000001, 32'hFFFFFFE3, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("op_f",        4'hF,    32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("op_9",        4'h9,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        in_valid = 1'b0;

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 50) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d results pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the course CPU datapath.
- Computes one of ten arithmetic, logic, shift or compare operations on two operands, selected by a 4-bit opcode.
- Result and the four condition flags (ZF, CF, OF, SF) are registered on the single clock.
- Sits between the register-file read ports and the writeback/branch logic.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported, and shift amounts use B[4:0].

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- ALU_OP  in  4  operation select
- ALU_A  in  32  operand A
- ALU_B  in  32  operand B
- ALU_F  out  32  registered result
- ZF  out  1  zero flag
- CF  out  1  carry/borrow flag
- OF  out  1  signed overflow flag
- SF  out  1  sign flag

Behaviour:
- One clock; reset is synchronous and active-high.
- When rst=1 at a rising clk edge: ALU_F=0, ZF=0, CF=0, OF=0, SF=0. Reset wins over any operation in flight.
- Latency is 1 cycle, with no handshake. Inputs are sampled every rising edge, and outputs reflect the inputs from the previous edge.
- Result and flags update together.
- Opcode map:
  - 0x0 ADD: A+B
  - 0x1 SLL: A<<B[4:0]
  - 0x2 SLT: signed A<B ? 1 : 0
  - 0x3 SLTU: unsigned A<B ? 1 : 0
  - 0x4 XOR
  - 0x5 SRL: logical A>>B[4:0]
  - 0x6 OR
  - 0x7 AND
  - 0x8 SUB: A-B
  - 0xD SRA: arithmetic A>>>B[4:0]
- Every other opcode: F=0, all flags computed as for a logic op, so ZF=1.
- Arithmetic is modulo 2^32; the result wraps and is never saturated.
- ZF = (F==0), for every opcode.
- SF = F[31], for every opcode.
- CF:
  - ADD: carry-out of bit 31.
  - SUB: borrow, i.e. 1 when A<B unsigned.
  - All other ops: 0.
- OF:
  - ADD: 1 iff A[31]==B[31] and F[31]!=A[31].
  - SUB: 1 iff A[31]!=B[31] and F[31]!=A[31].
  - All other ops: 0.
- SLT and SLTU must give the correct answer even when A-B overflows. SLT uses signed compare, not the subtract sign bit.
- Shift by 0 returns A unchanged. Only B[4:0] is used; B[31:5] is ignored.
- No X propagation from unused opcodes; all paths are fully assigned.

Optional Feature:
- Macro ALU_FR_EN.
- Defined: an extra output port ALU_FR (out, 4 bits) is added, equal to {ZF,CF,OF,SF}. It is registered identically to the individual flags and reset to 0.
- Undefined: the ALU_FR port does not exist; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD=4'h0, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND, OP_SUB=4'h8, OP_SRA=4'hD)
  - the WIDTH constant
  - the flag bit-index constants for ALU_FR
- One sub-module, alu_addsub:
  - Combinational 32-bit adder with sub control (A + ~B + 1).
  - Outputs sum, carry_out and overflow.
  - Shared by ADD, SUB, SLT and SLTU.
- Top level holds the op mux, the flag logic and the output registers.

Test Plan:
- rst=1 for 2 cycles with nonzero inputs -> all outputs 0. Release reset -> outputs follow inputs after 1 edge.
- A=0x00000003, B=0x00000607:
  - AND -> F=0x00000003, ZF=0
  - OR -> F=0x00000607
  - XOR -> F=0x00000604
  - ADD -> F=0x0000060A, CF=0, OF=0, SF=0
- Same operands:
  - SUB -> F=0xFFFFF9FC, CF=1, OF=0, SF=1, ZF=0
  - SLT -> F=1
  - SLTU -> F=1
- ADD A=0x80000000, B=0x80000000 -> F=0, ZF=1, CF=1, OF=1, SF=0. SUB A=0x80000000, B=1 -> F=0x7FFFFFFF, OF=1, CF=0. SLT on the same operands -> F=1.
- SUB A=B=0x7FFFFFFF -> F=0, ZF=1, CF=0, OF=0, SF=0.
- Shifts with A=0x80000001:
  - SLL by B=4 -> 0x00000010
  - SRL by B=4 -> 0x08000000
  - SRA by B=4 -> 0xF8000000
  - SRA by B=0x20 -> A unchanged
- Opcode 0xF -> F=0, ZF=1.
- With ALU_FR_EN defined, ALU_FR equals {ZF,CF,OF,SF} on every cycle.
